// File: rtl/fixed_dot_product_scheduler.sv
// Round-robin sharing of one fixed_dot_product engine between NUM_REQ requesters; an in-order tag FIFO
// routes each engine result back to its owner. Define FIXED_DOT_PRODUCT_SCHED_STATS_EN for grant counters.
module fixed_dot_product_scheduler #(
   parameter int NUM_REQ      = 4,
   parameter int IN_WIDTH     = 32,
   parameter int WEIGHT_WIDTH = 16,
   parameter int IN_SIZE      = 4,
   parameter int OUT_WIDTH    = IN_WIDTH + WEIGHT_WIDTH + $clog2(IN_SIZE),
   parameter int MAX_INFLIGHT = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [IN_WIDTH-1:0]                   req_data_in [NUM_REQ][IN_SIZE],
   input  logic [WEIGHT_WIDTH-1:0]               req_weight  [NUM_REQ][IN_SIZE],
   input  logic [NUM_REQ-1:0]                    req_valid,
   output logic [NUM_REQ-1:0]                    req_ready,
   output logic [IN_SIZE-1:0][IN_WIDTH-1:0]      dp_data_in,
   output logic                                  dp_data_in_valid,
   input  logic                                  dp_data_in_ready,
   output logic [IN_SIZE-1:0][WEIGHT_WIDTH-1:0]  dp_weight,
   output logic                                  dp_weight_valid,
   input  logic                                  dp_weight_ready,
   input  logic [OUT_WIDTH-1:0]                  dp_data_out,
   input  logic                                  dp_data_out_valid,
   output logic                                  dp_data_out_ready,
   output logic [OUT_WIDTH-1:0]                  res_data,
   output logic [NUM_REQ-1:0]                    res_valid,
   input  logic [NUM_REQ-1:0]                    res_ready,
   output logic [NUM_REQ-1:0][15:0]              stat_grant_count
);

   localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam logic [REQ_W-1:0] LAST_REQ  = REQ_W'(NUM_REQ - 1);
   localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(MAX_INFLIGHT - 1);
   localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_INFLIGHT);

   typedef enum logic {IDLE, ISSUE} state_e;

   state_e             state_q, state_d;
   logic [REQ_W-1:0]   g_q, g_d, ptr_q, ptr_d, g_inc;
   logic               d_done_q, d_done_d, w_done_q, w_done_d;
   logic               d_hs, w_hs, complete;

   logic [REQ_W-1:0]   tag_mem_q [MAX_INFLIGHT];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, wr_inc, rd_inc;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [REQ_W-1:0]   head_tag;
   logic               fifo_empty, push, pop;

   logic [NUM_REQ-1:0] eligible;
   logic [REQ_W-1:0]   arb_base, cand, pick;
   logic               found;

   // ---------------- issue side ----------------
   assign dp_data_in_valid = (state_q == ISSUE) && !d_done_q;
   assign dp_weight_valid  = (state_q == ISSUE) && !w_done_q;

   // NOTE: every signal driven in an always_comb gets a default on entry, so no path can infer a latch.
   always_comb begin
      d_hs     = dp_data_in_valid & dp_data_in_ready;
      w_hs     = dp_weight_valid & dp_weight_ready;
      complete = (state_q == ISSUE) && (d_done_q || d_hs) && (w_done_q || w_hs);
      g_inc    = (g_q == LAST_REQ) ? '0 : g_q + 1'b1;
      req_ready = '0;
      if (complete) req_ready[g_q] = 1'b1;
   end

   always_comb begin
      dp_data_in = '0;
      dp_weight  = '0;
      if (state_q == ISSUE) begin
         for (int e = 0; e < IN_SIZE; e++) begin
            dp_data_in[e] = req_data_in[g_q][e];
            dp_weight[e]  = req_weight[g_q][e];
         end
      end
   end

   // Eligibility looks at the occupancy after this cycle's push/pop, so a back-to-back
   // grant issued on the completion cycle can never overflow the tag FIFO.
   always_comb begin
      eligible = (count_d < MAX_CNT) ? req_valid : '0;
      arb_base = (state_q == ISSUE) ? g_inc : ptr_q;
      cand     = arb_base;
      found    = 1'b0;
      pick     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!found && eligible[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
         cand = (cand == LAST_REQ) ? '0 : cand + 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      g_d      = g_q;
      ptr_d    = ptr_q;
      d_done_d = d_done_q;
      w_done_d = w_done_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = ISSUE;
               g_d     = pick;
            end
         end
         ISSUE: begin
            if (d_hs) d_done_d = 1'b1;
            if (w_hs) w_done_d = 1'b1;
            if (complete) begin
               d_done_d = 1'b0;
               w_done_d = 1'b0;
               ptr_d    = g_inc;
               if (found) g_d = pick;
               else       state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         g_q      <= '0;
         ptr_q    <= '0;
         d_done_q <= 1'b0;
         w_done_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         g_q      <= g_d;
         ptr_q    <= ptr_d;
         d_done_q <= d_done_d;
         w_done_q <= w_done_d;
      end
   end

   // ---------------- tag FIFO and return path ----------------
   assign push       = complete;
   assign fifo_empty = (count_q == '0);
   assign head_tag   = tag_mem_q[rd_ptr_q];
   assign pop        = dp_data_out_valid & dp_data_out_ready;
   assign count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
   assign wr_inc     = (wr_ptr_q == LAST_SLOT) ? '0 : wr_ptr_q + 1'b1;
   assign rd_inc     = (rd_ptr_q == LAST_SLOT) ? '0 : rd_ptr_q + 1'b1;
   assign res_data   = dp_data_out;

   always_comb begin
      res_valid         = '0;
      dp_data_out_ready = 1'b0;
      if (!fifo_empty) begin
         res_valid[head_tag] = dp_data_out_valid;
         dp_data_out_ready   = res_ready[head_tag];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_inc;
         if (pop)  rd_ptr_q <= rd_inc;
         count_q <= count_d;
      end
   end

   // NOTE: tag storage is not reset; the pointers and count alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) tag_mem_q[wr_ptr_q] <= g_q;
   end

   // ---------------- optional grant statistics ----------------
`ifdef FIXED_DOT_PRODUCT_SCHED_STATS_EN
   logic [NUM_REQ-1:0][15:0] stat_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_q <= '0;
      end else if (complete && (stat_q[g_q] != 16'hFFFF)) begin
         stat_q[g_q] <= stat_q[g_q] + 16'd1;
      end
   end

   assign stat_grant_count = stat_q;
`else
   assign stat_grant_count = '0;
`endif

endmodule

// File: tb/tb_fixed_dot_product_scheduler.sv
// Self-checking bench for fixed_dot_product_scheduler: transaction-level model plus a bench engine,
// checked every cycle at the falling edge, with directed scenarios pinning literal expectations.
module tb_fixed_dot_product_scheduler;

   logic clk = 1'b0;
   logic rst;
   logic [31:0]       req_data_in [4][4];
   logic [15:0]       req_weight  [4][4];
   logic [3:0]        req_valid, req_ready, res_valid, res_ready;
   logic [3:0][31:0]  dp_data_in;
   logic [3:0][15:0]  dp_weight;
   logic              dp_data_in_valid, dp_data_in_ready, dp_weight_valid, dp_weight_ready;
   logic [49:0]       dp_data_out = '0;
   logic              dp_data_out_valid = 1'b0;
   logic              dp_data_out_ready;
   logic [49:0]       res_data;
   logic [3:0][15:0]  stat_grant_count;

   always #5 clk = ~clk;

   fixed_dot_product_scheduler dut (
      .clk(clk), .rst(rst),
      .req_data_in(req_data_in), .req_weight(req_weight),
      .req_valid(req_valid), .req_ready(req_ready),
      .dp_data_in(dp_data_in), .dp_data_in_valid(dp_data_in_valid), .dp_data_in_ready(dp_data_in_ready),
      .dp_weight(dp_weight), .dp_weight_valid(dp_weight_valid), .dp_weight_ready(dp_weight_ready),
      .dp_data_out(dp_data_out), .dp_data_out_valid(dp_data_out_valid), .dp_data_out_ready(dp_data_out_ready),
      .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
      .stat_grant_count(stat_grant_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction model state ----------------
   int          owner = -1;
   int          next_owner = -1;
   int          mptr = 0;
   bit          dd, wd;
   int          tag_q[$];
   logic [63:0] exp_q[$];
   int          grant_log[$];
   int          grant_cyc[$];
   int          res_log[$];
   int          stat_m[4];
   int          cyc = 0;
   int          n_dhs = 0;
   bit          eng_en = 1'b0;
   bit          ed, ew;
   logic [3:0][31:0] ecap_d;
   logic [3:0][15:0] ecap_w;
   logic [63:0] eng_q[$];

   function automatic logic [63:0] dot_req(input int r);
      logic [63:0] s;
      s = '0;
      for (int e = 0; e < 4; e++) s += 64'(req_data_in[r][e]) * 64'(req_weight[r][e]);
      return s;
   endfunction

   function automatic logic [63:0] dot_cap(input logic [3:0][31:0] d, input logic [3:0][15:0] w);
      logic [63:0] s;
      s = '0;
      for (int e = 0; e < 4; e++) s += 64'(d[e]) * 64'(w[e]);
      return s;
   endfunction

   // First valid requester at or after base, wrapping.
   function automatic int rr_pick(input int base, input logic [3:0] v);
      int idx;
      for (int k = 0; k < 4; k++) begin
         idx = (base + k) % 4;
         if (v[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   // Bench engine: drives its result queue head a little after each rising edge.
   always @(posedge clk) begin
      #2;
      dp_data_out_valid = eng_en && (eng_q.size() > 0);
      dp_data_out       = (eng_q.size() > 0) ? eng_q[0][49:0] : '0;
   end

   // ---------------- per-cycle compare process ----------------
   logic              m_dhs, m_whs, m_ohs, m_done;
   int                m_h;
   logic [3:0][31:0]  m_xd;
   logic [3:0][15:0]  m_xw;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         check("rst_req_ready", req_ready, 0);
         check("rst_dp_data_in_valid", dp_data_in_valid, 0);
         check("rst_dp_weight_valid", dp_weight_valid, 0);
         check("rst_dp_data_out_ready", dp_data_out_ready, 0);
         check("rst_res_valid", res_valid, 0);
         check("rst_stat", stat_grant_count, 0);
         owner = -1; next_owner = -1; mptr = 0; dd = 0; wd = 0; ed = 0; ew = 0;
         tag_q.delete(); exp_q.delete(); grant_log.delete(); grant_cyc.delete();
         res_log.delete(); eng_q.delete();
         for (int r = 0; r < 4; r++) stat_m[r] = 0;
      end else begin
`ifdef FIXED_DOT_PRODUCT_SCHED_STATS_EN
         for (int r = 0; r < 4; r++) check($sformatf("stat%0d", r), stat_grant_count[r], 64'(stat_m[r]));
`else
         check("stat_tied_zero", stat_grant_count, 0);
`endif
         m_dhs = dp_data_in_valid & dp_data_in_ready;
         m_whs = dp_weight_valid & dp_weight_ready;
         if ((dp_data_in_valid || dp_weight_valid) && owner < 0) begin
            owner = next_owner;
            check("issue_has_candidate", owner >= 0, 1);
         end
         check("dp_data_in_valid", dp_data_in_valid, owner >= 0 && !dd);
         check("dp_weight_valid", dp_weight_valid, owner >= 0 && !wd);
         if (owner >= 0) begin
            for (int e = 0; e < 4; e++) begin
               m_xd[e] = req_data_in[owner][e];
               m_xw[e] = req_weight[owner][e];
            end
            if (dp_data_in_valid) check("dp_data_in_route", dp_data_in == m_xd, 1);
            if (dp_weight_valid)  check("dp_weight_route", dp_weight == m_xw, 1);
         end
         m_done = (owner >= 0) && (dd || m_dhs) && (wd || m_whs);
         check("req_ready", req_ready, m_done ? (64'd1 << owner) : 64'd0);
         dd = dd | m_dhs;
         wd = wd | m_whs;
         n_dhs += int'(m_dhs);

         if (m_dhs) begin ecap_d = dp_data_in; ed = 1; end
         if (m_whs) begin ecap_w = dp_weight;  ew = 1; end
         if (ed && ew) begin
            eng_q.push_back(dot_cap(ecap_d, ecap_w));
            ed = 0; ew = 0;
         end

         m_ohs = dp_data_out_valid & dp_data_out_ready;
         if (tag_q.size() > 0) begin
            m_h = tag_q[0];
            check("res_valid", res_valid, dp_data_out_valid ? (64'd1 << m_h) : 64'd0);
            check("dp_data_out_ready", dp_data_out_ready, res_ready[m_h]);
            check("res_data_pass", res_data, dp_data_out);
            if (m_ohs) begin
               check("res_value", res_data, exp_q[0]);
               res_log.push_back(m_h);
               void'(tag_q.pop_front());
               void'(exp_q.pop_front());
            end
         end else begin
            check("res_valid_empty", res_valid, 0);
            check("dp_data_out_ready_empty", dp_data_out_ready, 0);
         end
         if (m_ohs && eng_q.size() > 0) void'(eng_q.pop_front());

         if (m_done) begin
            tag_q.push_back(owner);
            exp_q.push_back(dot_req(owner));
            grant_log.push_back(owner);
            grant_cyc.push_back(cyc);
            if (stat_m[owner] < 65535) stat_m[owner]++;
            mptr = (owner + 1) % 4;
            owner = -1; dd = 0; wd = 0;
            check("inflight_bound", tag_q.size() <= 8, 1);
         end
         if (owner < 0) next_owner = rr_pick(mptr, (tag_q.size() < 8) ? req_valid : 4'b0);
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0; dp_data_in_ready = 0; dp_weight_ready = 0; res_ready = '0; eng_en = 0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic wait_grants(input int n, input string name);
      int k;
      k = 0;
      while (grant_log.size() < n && k < 300) begin tick(); k++; end
      check(name, grant_log.size() >= n, 1);
   endtask

   int zeros;
   int base_dhs;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0; dp_data_in_ready = 0; dp_weight_ready = 0; res_ready = '0;
      for (int r = 0; r < 4; r++)
         for (int e = 0; e < 4; e++) begin
            req_data_in[r][e] = {4'(r + 1), 28'(e * 12345 + 7)};
            req_weight[r][e]  = 16'(16'hA000 + r * 256 + e);
         end
      tick(); tick();
      check("reset_req_ready", req_ready, 4'b0000);
      check("reset_dp_valid", {dp_data_in_valid, dp_weight_valid}, 2'b00);
      check("reset_res_valid", res_valid, 4'b0000);

      // All requesters valid, engine always ready: 20 issues in strict rotation.
      do_reset();
      req_valid = 4'hF; dp_data_in_ready = 1; dp_weight_ready = 1; res_ready = 4'hF; eng_en = 1;
      wait_grants(19, "t1_wait");
      req_valid = 4'h0;
      repeat (20) tick();
      check("t1_total_grants", grant_log.size(), 20);
      for (int i = 0; i < 8 && i < grant_log.size(); i++)
         check($sformatf("t1_grant%0d", i), grant_log[i], i % 4);
      for (int i = 1; i < grant_cyc.size(); i++)
         check($sformatf("t1_gap%0d", i), grant_cyc[i] - grant_cyc[i-1], 1);
      check("t1_total_results", res_log.size(), 20);
      for (int i = 0; i < 4 && i < res_log.size(); i++)
         check($sformatf("t1_res%0d", i), res_log[i], i);
`ifdef FIXED_DOT_PRODUCT_SCHED_STATS_EN
      for (int r = 0; r < 4; r++) check($sformatf("t1_stat%0d", r), stat_grant_count[r], 5);
`else
      check("t1_stat_zero", stat_grant_count, 0);
`endif

      // Weight channel accepted three cycles after the data channel.
      do_reset();
      req_valid = 4'b0001; dp_data_in_ready = 1; dp_weight_ready = 0; res_ready = 4'hF; eng_en = 1;
      base_dhs = n_dhs;
      for (int k = 0; k < 50 && n_dhs == base_dhs; k++) tick();
      for (int k = 0; k < 3; k++) begin
         check("t2_data_valid_dropped", dp_data_in_valid, 0);
         check("t2_weight_valid_held", dp_weight_valid, 1);
         check("t2_no_ready_yet", req_ready, 4'b0000);
         tick();
      end
      dp_weight_ready = 1; req_valid = 4'b0000;
      #1;
      check("t2_ready_pulse", req_ready, 4'b0001);
      tick();
      check("t2_ready_gone", req_ready, 4'b0000);
      repeat (5) tick();
      check("t2_one_push", grant_log.size(), 1);

      // Engine stalls its output: the FIFO fills at eight, one pop admits exactly one more.
      do_reset();
      req_valid = 4'hF; dp_data_in_ready = 1; dp_weight_ready = 1; res_ready = 4'hF; eng_en = 0;
      repeat (40) tick();
      check("t3_grants_at_full", grant_log.size(), 8);
      check("t3_ready_idle", req_ready, 4'b0000);
      check("t3_no_results", res_log.size(), 0);
      eng_en = 1;
      tick();
      eng_en = 0;
      repeat (20) tick();
      check("t3_one_pop", res_log.size(), 1);
      check("t3_one_more_grant", grant_log.size(), 9);

      // Single requester with a known dot product, result held back by res_ready.
      do_reset();
      for (int e = 0; e < 4; e++) begin
         req_data_in[2][e] = 32'(e + 1);
         req_weight[2][e]  = 16'(e + 5);
      end
      dp_data_in_ready = 1; dp_weight_ready = 1; res_ready = 4'b0000; eng_en = 1;
      req_valid = 4'b0100;
      #1;
      check("t4_valid_not_same_cycle", dp_data_in_valid, 0);
      tick();
      check("t4_valid_next_cycle", {dp_data_in_valid, dp_weight_valid}, 2'b11);
      check("t4_ready_owner2", req_ready, 4'b0100);
      req_valid = 4'b0000;
      repeat (3) tick();
      #2;
      check("t4_res_valid", res_valid, 4'b0100);
      check("t4_res_data", res_data, 70);
      check("t4_stall", dp_data_out_ready, 0);
      tick();
      check("t4_still_stalled", dp_data_out_ready, 0);
      res_ready = 4'b0100;
      #1;
      check("t4_released", dp_data_out_ready, 1);
      repeat (3) tick();
      check("t4_one_result", res_log.size(), 1);
      if (res_log.size() > 0) check("t4_result_owner", res_log[0], 2);

      // Reset in the middle of an issue with three tags outstanding.
      do_reset();
      req_valid = 4'hF; dp_data_in_ready = 1; dp_weight_ready = 1; res_ready = 4'hF; eng_en = 0;
      wait_grants(3, "t5_wait");
      dp_data_in_ready = 0; dp_weight_ready = 0;
      #1;
      check("t5_in_issue", dp_data_in_valid, 1);
      check("t5_head_ready", dp_data_out_ready, 1);
      rst = 1'b1;
      #1;
      check("t5_async_req_ready", req_ready, 0);
      check("t5_async_dp_valid", {dp_data_in_valid, dp_weight_valid}, 0);
      check("t5_async_out_ready", dp_data_out_ready, 0);
      check("t5_async_res_valid", res_valid, 0);
      tick(); tick();
      rst = 1'b0;
      dp_data_in_ready = 1; dp_weight_ready = 1; eng_en = 1;
      wait_grants(1, "t5_wait_after");
      if (grant_log.size() > 0) check("t5_first_grant", grant_log[0], 0);
      req_valid = 4'h0;
      repeat (10) tick();
      check("t5_results", res_log.size(), 2);
      if (res_log.size() > 0) check("t5_first_result_owner", res_log[0], 0);

      // Requesters 1 and 3 only, pointer parked at 2 after serving requester 1.
      do_reset();
      dp_data_in_ready = 1; dp_weight_ready = 1; res_ready = 4'hF; eng_en = 1;
      req_valid = 4'b0010;
      tick();
      req_valid = 4'b1010;
      wait_grants(5, "t6_wait");
      req_valid = 4'b0000;
      repeat (10) tick();
      if (grant_log.size() >= 4) begin
         check("t6_g0", grant_log[0], 1);
         check("t6_g1", grant_log[1], 3);
         check("t6_g2", grant_log[2], 1);
         check("t6_g3", grant_log[3], 3);
      end
      zeros = 0;
      foreach (grant_log[i]) if (grant_log[i] == 0) zeros++;
      check("t6_req0_never", zeros, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fixed_dot_product_scheduler.md
Name: fixed_dot_product_scheduler

Overview:
- Shares one fixed_dot_product engine between NUM_REQ requesters.
- Each requester presents a paired activation/weight vector. The block grants requesters round-robin and drives the engine's data_in and weight channels.
- An in-order tag FIFO records which requester owns each in-flight operation, so each engine result is routed back to its owner.
- Sits between the layer-level control units and a single dot-product datapath.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- IN_WIDTH, 32, activation element width
- WEIGHT_WIDTH, 16, weight element width
- IN_SIZE, 4, vector length (block size)
- OUT_WIDTH, IN_WIDTH+WEIGHT_WIDTH+$clog2(IN_SIZE), result width
- MAX_INFLIGHT, 8, tag FIFO depth; must be a power of 2

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_data_in  in  [NUM_REQ][IN_SIZE][IN_WIDTH] unpacked  per-requester activations
- req_weight  in  [NUM_REQ][IN_SIZE][WEIGHT_WIDTH] unpacked  per-requester weights
- req_valid  in  NUM_REQ  request valid, one bit per requester
- req_ready  out  NUM_REQ  request accepted, one-hot or zero
- dp_data_in  out  [IN_SIZE][IN_WIDTH]  to engine
- dp_data_in_valid  out  1
- dp_data_in_ready  in  1
- dp_weight  out  [IN_SIZE][WEIGHT_WIDTH]  to engine
- dp_weight_valid  out  1
- dp_weight_ready  in  1
- dp_data_out  in  OUT_WIDTH  engine result
- dp_data_out_valid  in  1
- dp_data_out_ready  out  1
- res_data  out  OUT_WIDTH  result, broadcast to all requesters
- res_valid  out  NUM_REQ  one-hot: owner of the current result
- res_ready  in  NUM_REQ  per-requester result ready
- stat_grant_count  out  [NUM_REQ][16]  see Optional Feature

Behaviour:
- States:
  - IDLE: no grant.
  - ISSUE: grant register g holds the owner; both channels are driven from requester g.
- Arbitration:
  - Eligible requesters are req_valid bits with the tag FIFO not full (count < MAX_INFLIGHT).
  - Search starts at pointer ptr and wraps NUM_REQ-1 → 0. ptr resets to 0.
  - IDLE → ISSUE when any requester is eligible; g is registered. dp_*_valid first rises in the following cycle.
- Issue handshake:
  - In ISSUE, dp_data_in_valid = !d_done and dp_weight_valid = !w_done.
  - d_done/w_done set on each channel's handshake. Channels may be accepted in different cycles.
- Issue completion (cycle in which the last outstanding channel handshakes):
  - req_ready[g]=1 for that cycle only.
  - g is pushed into the tag FIFO; ptr ← g+1 (mod NUM_REQ); d_done/w_done cleared.
  - Re-arbitration uses the updated ptr, combinationally in the same cycle: if another requester is eligible, g reloads and the block stays in ISSUE (back-to-back, no bubble); else → IDLE.
- Grant stability:
  - Grant is never revoked mid-issue, even if req_valid[g] drops (protocol violation).
  - Requester data must be held stable until req_ready.
- Return path (only when the FIFO is non-empty, head tag h):
  - res_valid[h]=dp_data_out_valid, all other res_valid bits 0.
  - dp_data_out_ready=res_ready[h]; res_data=dp_data_out, passed through combinationally with zero added latency.
  - Pop on the dp_data_out handshake.
- Empty FIFO:
  - dp_data_out_ready=0 and res_valid=0. The result stalls in the engine and is not dropped.
- FIFO:
  - Simultaneous push and pop leaves the count unchanged. Push at full is impossible by the eligibility rule.
  - Pointers wrap modulo MAX_INFLIGHT.
- Reset values: state=IDLE, ptr=0, g=0, FIFO empty, d_done=w_done=0. All outputs 0 (req_ready, dp_*_valid, dp_data_out_ready, res_valid, stat_grant_count).
- Reset mid-operation: in-flight tags are discarded. The engine is required to be reset by the same rst.

Optional Feature:
- Macro: FIXED_DOT_PRODUCT_SCHED_STATS_EN.
- Defined: stat_grant_count[i] increments on each issue completion for requester i, saturates at 16'hFFFF, and clears on rst.
- Undefined: no counter registers are built; stat_grant_count is tied to 0. Port list is identical in both builds.

Test Plan:
- All 4 requesters valid continuously, engine always ready → grants 0,1,2,3,0,… one per cycle after the first. Results are routed with res_valid one-hot in the same order. Stats enabled: counts all equal 5 after 20 issues.
- dp_weight_ready delayed 3 cycles after dp_data_in_ready → dp_data_in_valid drops after its handshake. req_ready[g] pulses exactly once, in the weight-handshake cycle; exactly one push.
- Engine holds dp_data_out_valid=0 with MAX_INFLIGHT=8 → after 8 issues no further grant, req_ready stays 0. One result popped → exactly one new issue.
- Requester 2 only, data [1,2,3,4], weights [5,6,7,8] with a model engine → res_valid=4'b0100, res_data=70. With res_ready[2]=0, dp_data_out_ready stays 0 until res_ready[2]=1.
- rst asserted while in ISSUE with 3 tags in flight → outputs go 0 asynchronously. After release, FIFO empty and the first grant goes to requester 0.
- Requesters 1 and 3 valid, ptr=2 → grant 3 then 1; requester 0 never granted.
